// File: rtl/output_serializer_if.sv
// Controller-to-host bundle of the output serializer: strobed 3-value entries in,
// one value per valid/ready handshake out, plus backpressure and error flags.
interface output_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [31:0]           in_x;
  logic [31:0]           in_y;
  logic [31:0]           in_ch;
  logic [DATA_WIDTH-1:0] in_data0;
  logic [DATA_WIDTH-1:0] in_data1;
  logic [DATA_WIDTH-1:0] in_data2;
  logic                  stall;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [31:0]           out_x;
  logic [31:0]           out_y;
  logic [31:0]           out_ch;
  logic                  overflow_err;

  // Driver side: controller strobes and host ready.
  modport master (
    output in_valid, in_x, in_y, in_ch, in_data0, in_data1, in_data2, out_ready,
    input  stall, out_valid, out_data, out_x, out_y, out_ch, overflow_err
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_x, in_y, in_ch, in_data0, in_data1, in_data2, out_ready,
    output stall, out_valid, out_data, out_x, out_y, out_ch, overflow_err
  );
endinterface

// File: rtl/output_serializer.sv
// Buffers {x, y, ch, 3 values} entries in a small FIFO and presents them to the
// host one channel value at a time, with almost-full stall and sticky overflow.
module output_serializer #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input logic                 clk,
  input logic                 arst_n_in,
  input logic                 clear,
  output_serializer_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]           r_x  [FIFO_DEPTH];
  logic [31:0]           r_y  [FIFO_DEPTH];
  logic [31:0]           r_ch [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_d0 [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_d1 [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_d2 [FIFO_DEPTH];
  logic [1:0]            r_n  [FIFO_DEPTH];

  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic [1:0]      r_lane;
  logic            r_ovf;

  logic                  w_in_range;
  logic [31:0]           w_rem;
  logic [1:0]            w_n;
  logic                  w_valid;
  logic                  w_full;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_head_data;

  always_comb begin
    w_in_range = bus.in_ch < 32'(OUTPUT_NB_CHANNELS);
    w_rem      = 32'(OUTPUT_NB_CHANNELS) - bus.in_ch;
    w_n        = (w_rem >= 32'd3) ? 2'd3 : w_rem[1:0];
    w_valid    = (r_count != '0);
    w_full     = (r_count == CntW'(FIFO_DEPTH));
    w_xfer     = w_valid && bus.out_ready;
    w_pop      = w_xfer && (r_lane == (r_n[r_rptr] - 2'd1));
    // A full FIFO still accepts a push when the head retires in the same cycle.
    w_push     = bus.in_valid && w_in_range && (!w_full || w_pop) && !clear;
    w_drop     = bus.in_valid && w_in_range && w_full && !w_pop && !clear;
  end

  // Payload storage needs no reset: nothing is presented while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_x[r_wptr]  <= bus.in_x;
      r_y[r_wptr]  <= bus.in_y;
      r_ch[r_wptr] <= bus.in_ch;
      r_d0[r_wptr] <= bus.in_data0;
      r_d1[r_wptr] <= bus.in_data1;
      r_d2[r_wptr] <= bus.in_data2;
      r_n[r_wptr]  <= w_n;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_lane  <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_lane  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      if (w_pop) begin
        r_lane <= '0;
      end else if (w_xfer) begin
        r_lane <= r_lane + 2'd1;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    unique case (r_lane)
      2'd0:    w_head_data = r_d0[r_rptr];
      2'd1:    w_head_data = r_d1[r_rptr];
      default: w_head_data = r_d2[r_rptr];
    endcase
  end

  // Outputs are forced to zero when empty so reset reads back all-zero.
  assign bus.out_valid    = w_valid;
  assign bus.out_data     = w_valid ? w_head_data : '0;
  assign bus.out_x        = w_valid ? r_x[r_rptr] : '0;
  assign bus.out_y        = w_valid ? r_y[r_rptr] : '0;
  assign bus.out_ch       = w_valid ? (r_ch[r_rptr] + 32'(r_lane)) : '0;
  assign bus.stall        = (r_count >= CntW'(FIFO_DEPTH - 2));
  assign bus.overflow_err = r_ovf;

endmodule

// File: tb/tb_output_serializer.sv
// Randomized and directed bench for output_serializer against a value-queue model.
module tb_output_serializer;

  localparam int unsigned Dw    = 32;
  localparam int unsigned NbCh  = 64;
  localparam int unsigned Depth = 4;

  logic clk;
  logic arst_n_in;
  logic clear;

  output_serializer_if #(.DATA_WIDTH(Dw)) bus ();

  output_serializer #(
    .DATA_WIDTH         (Dw),
    .OUTPUT_NB_CHANNELS (NbCh),
    .FIFO_DEPTH         (Depth)
  ) u_dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clear     (clear),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a flat queue of the individual values still owed to the host.
  typedef struct {
    logic [31:0]   x;
    logic [31:0]   y;
    logic [31:0]   ch;
    logic [Dw-1:0] d;
    bit            last;
  } rec_t;

  rec_t q[$];
  bit   m_ovf;
  int   n_vec;
  int   n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Entries still held = values that end an entry.
  function automatic int occupancy();
    int c = 0;
    foreach (q[i]) if (q[i].last) c++;
    return c;
  endfunction

  task automatic check_outputs();
    check_eq("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("out_data", 64'(bus.out_data), 64'(q[0].d));
      check_eq("out_x",    64'(bus.out_x),    64'(q[0].x));
      check_eq("out_y",    64'(bus.out_y),    64'(q[0].y));
      check_eq("out_ch",   64'(bus.out_ch),   64'(q[0].ch));
    end
    check_eq("stall",        64'(bus.stall),        64'(occupancy() >= int'(Depth) - 2));
    check_eq("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
  endtask

  // One cycle: check what is presented, drive new inputs, advance the model past the edge.
  task automatic step(input bit v, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ch, input logic [Dw-1:0] d0, input logic [Dw-1:0] d1,
                      input logic [Dw-1:0] d2, input bit rdy, input bit clr);
    logic [Dw-1:0] d [3];
    int   n;
    bit   xfer;
    bit   retire;
    bit   full;
    @(negedge clk);
    check_outputs();
    bus.in_valid  = v;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.in_ch     = ch;
    bus.in_data0  = d0;
    bus.in_data1  = d1;
    bus.in_data2  = d2;
    bus.out_ready = rdy;
    clear         = clr;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      xfer   = (q.size() != 0) && rdy;
      retire = xfer && q[0].last;
      full   = (occupancy() == int'(Depth));
      if (xfer) void'(q.pop_front());
      if (v && ch < NbCh) begin
        if (!full || retire) begin
          d[0] = d0; d[1] = d1; d[2] = d2;
          n = (int'(NbCh) - int'(ch) < 3) ? int'(NbCh) - int'(ch) : 3;
          for (int i = 0; i < n; i++) begin
            q.push_back('{x: x, y: y, ch: ch + 32'(i), d: d[i], last: (i == n - 1)});
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int cycles, input bit rdy);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic strobe(input logic [31:0] ch, input bit rdy);
    step(1, $urandom, $urandom, ch, $urandom, $urandom, $urandom, rdy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear        = 1'b0;
    arst_n_in    = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_ovf",       64'(bus.overflow_err), 64'd0);
    check_eq("rst_stall",     64'(bus.stall), 64'd0);
    check_eq("rst_out_data",  64'(bus.out_data), 64'd0);
    check_eq("rst_out_ch",    64'(bus.out_ch), 64'd0);
    q.delete();
    m_ovf = 1'b0;
    #12;
    arst_n_in = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_ovf = 1'b0;
    arst_n_in     = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_ch     = '0;
    bus.in_data0  = '0;
    bus.in_data1  = '0;
    bus.in_data2  = '0;
    bus.out_ready = 1'b0;
    #1;
    check_eq("init_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("init_out_x",     64'(bus.out_x), 64'd0);
    #20;
    arst_n_in = 1'b1;

    // Single strobe, three values on consecutive cycles.
    step(1, 2, 5, 6, 10, 11, 12, 1, 0);
    idle(5, 1);

    // Two entries back to back with toggling ready.
    strobe(0, 1);
    strobe(3, 0);
    for (int i = 0; i < 14; i++) idle(1, (i % 2) == 0);

    // Channel boundary: last channel yields one value, out-of-range pushes nothing.
    strobe(63, 1);
    strobe(66, 1);
    idle(3, 1);
    strobe(62, 0);
    idle(4, 1);

    // Fill with host stalled, overflow on the fifth, then drain all twelve.
    for (int i = 0; i < 5; i++) strobe(32'(3 * i), 0);
    check_eq("full_ovf_set", 64'(m_ovf), 64'd1);
    idle(16, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Full FIFO whose head retires in the same cycle as a new push.
    strobe(63, 0);
    strobe(3, 0);
    strobe(6, 0);
    strobe(9, 0);
    step(1, 7, 7, 30, 1, 2, 3, 1, 0);
    idle(14, 1);

    // Reset in the middle of draining an entry.
    strobe(0, 0);
    idle(1, 1);
    pulse_reset();
    idle(4, 1);

    // Random traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) != 0, $urandom, $urandom, $urandom_range(0, 70),
           $urandom, $urandom, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 60) == 0);
    end
    // Random traffic with a mostly stalled host to exercise overflow.
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 1) != 0, $urandom, $urandom, $urandom_range(0, 66),
           $urandom, $urandom, $urandom, $urandom_range(0, 3) == 0,
           $urandom_range(0, 100) == 0);
      if (i == 500) pulse_reset();
    end
    idle(20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of each output-feature value.
REQ-002 The block SHALL have parameter OUTPUT_NB_CHANNELS, default 64, giving the total number of output channels.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of 3-value entries held; it is a power of two and at least 4.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port arst_n_in, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port clear, input, 1 bit, a synchronous flush of all state, including the sticky flag.
REQ-007 The block SHALL have port in_valid, input, 1 bit, the one-cycle strobe from the controller's output_valid.
REQ-008 The block SHALL have ports in_x, in_y, in_ch, input, 32 bits each, the output coordinate tag and base channel.
REQ-009 The block SHALL have ports in_data0, in_data1, in_data2, input, DATA_WIDTH each, the datapath values for channels in_ch+0, in_ch+1 and in_ch+2.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning a value is presented to the host.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the host accepts the presented value.
REQ-012 The block SHALL have port out_data, output, DATA_WIDTH, the presented value.
REQ-013 The block SHALL have ports out_x, out_y, out_ch, output, 32 bits each, the coordinate tag of the presented value.
REQ-014 The block SHALL have port stall, output, 1 bit, meaning almost-full backpressure toward the controller.
REQ-015 The block SHALL have port overflow_err, output, 1 bit, a sticky flag meaning an entry was lost.

Function
REQ-016 When in_valid=1, the block SHALL capture one entry {x, y, ch, data0..2, n} at the rising edge, where n = min(3, OUTPUT_NB_CHANNELS - in_ch).
REQ-017 When in_valid=1 and in_ch >= OUTPUT_NB_CHANNELS, the block SHALL push nothing and leave overflow_err unaffected.
REQ-018 The FIFO SHALL have registered storage with no bypass: an entry pushed at edge t gives out_valid=1 no earlier than the cycle after edge t.
REQ-019 out_valid SHALL equal (FIFO not empty) and SHALL be a function of registers only.
REQ-020 The presented value SHALL come from the head entry and lane counter lane (2 bits, range 0..2): out_data = data[lane], out_x = x, out_y = y, out_ch = ch + lane (32-bit, no wrap expected).
REQ-021 A transfer SHALL occur when out_valid && out_ready.
REQ-022 On a transfer with lane == n-1, the block SHALL pop the head and set lane to 0; on any other transfer it SHALL increment lane.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_x, out_y and out_ch SHALL hold stable, and the block SHALL NOT drop out_valid.
REQ-024 Push and pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-025 A push SHALL be accepted when full only if a pop occurs in the same cycle.
REQ-026 When in_valid=1 while full with no pop, the block SHALL drop the new entry, set overflow_err (sticky), and leave the stored entries unchanged.
REQ-027 stall SHALL equal (occupancy >= FIFO_DEPTH-2), registered-occupancy based, so that two back-to-back controller strobes (CC_4, CC_5) are always absorbed after stall rises.
REQ-028 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; occupancy SHALL be a separate counter of log2(FIFO_DEPTH)+1 bits.
REQ-029 clear=1 SHALL, at the next edge, empty the FIFO, set lane=0 and set overflow_err=0; pushes and transfers in that same cycle SHALL be ignored.

Reset
REQ-030 While arst_n_in=0, asynchronously: out_valid=0, stall=0, overflow_err=0, lane=0, pointers=0, occupancy=0; out_data, out_x, out_y and out_ch SHALL read 0.
REQ-031 An assertion of reset mid-drain SHALL discard all pending entries; after release, the first out_valid SHALL appear only after a new in_valid.

Verification
REQ-032 Scenario: one strobe in_ch=6, x=2, y=5, data 10/11/12, out_ready=1 -> three transfers (ch 6,7,8; data 10,11,12; x=2, y=5) on consecutive cycles starting the cycle after the push, then out_valid=0.
REQ-033 Scenario: strobes ch=0 then ch=3 back-to-back, out_ready toggling 1,0 -> six values in order (ch 0..5), each held stable while out_ready=0.
REQ-034 Scenario: OUTPUT_NB_CHANNELS=64, in_ch=63 -> exactly one transfer with ch 63; a strobe with in_ch=66 -> no push and overflow_err stays 0.
REQ-035 Scenario: out_ready=0 and 4 strobes with FIFO_DEPTH=4 -> stall=1 after the 2nd push, full after the 4th; a 5th strobe sets overflow_err=1; after releasing out_ready, exactly 12 values drain.
REQ-036 Scenario: full FIFO with out_ready=1 and in_valid=1 in the same cycle -> occupancy stays 4, no overflow, and the new entry drains last.
REQ-037 Scenario: arst_n_in pulsed low mid-drain (lane=1) -> out_valid=0 immediately, overflow_err=0, and no stale value appears after release.
